// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone bridge: region codes, FSM state
// encoding, default parameter values and small helpers.
package wb_bridge_pkg;

    // Default parameter values for the bridge and its decoder
    localparam int DEF_LOG_CORES   = 3;
    localparam int DEF_PC_WIDTH    = 8;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_IO_PINS     = 16;
    localparam int DEF_WB_WIDTH    = 32;
    localparam int DEF_DEBUG_LAT   = 2;

    // Wait counter wide enough for DEBUG_LAT up to 15
    localparam int LAT_CNT_WIDTH   = 4;

    // Width of the optional acknowledge statistics counter
    localparam int STATS_WIDTH     = 16;

    // Target region selected by the two top address bits
    typedef enum logic [1:0] {
        REGION_PROG    = 2'b00,
        REGION_PADS    = 2'b01,
        REGION_DEBUG   = 2'b10,
        REGION_ENTROPY = 2'b11
    } region_e;

    // Bus-side transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Counter preload for a debug read: the capture happens when it hits 0
    function automatic logic [LAT_CNT_WIDTH-1:0] lat_load(input int lat);
        return LAT_CNT_WIDTH'(lat - 1);
    endfunction

endpackage

// File: rtl/wb_bridge_decode.sv
// Combinational address field decode for the Wishbone bridge.
// Splits a bus address into its region and per-region target fields.
module wb_bridge_decode
    import wb_bridge_pkg::*;
#(
    parameter int LOG_CORES = DEF_LOG_CORES,
    parameter int PC_WIDTH  = DEF_PC_WIDTH,
    parameter int WB_WIDTH  = DEF_WB_WIDTH
) (
    input  logic [WB_WIDTH-1:0]  adr,
    output region_e              region,
    output logic [LOG_CORES-1:0] prog_sel,
    output logic [PC_WIDTH-1:0]  prog_waddr,
    output logic                 pads_waddr,
    output logic [LOG_CORES-1:0] debug_sel,
    output logic [4:0]           debug_addr
);

    // Address bits between the field and the region code are don't-care
    logic unused_adr;
    assign unused_adr = ^adr;

    // Slice the address into region and per-target fields
    always_comb begin
        region     = region_e'(adr[WB_WIDTH-1 -: 2]);
        prog_sel   = adr[PC_WIDTH +: LOG_CORES];
        prog_waddr = adr[PC_WIDTH-1:0];
        pads_waddr = adr[0];
        debug_sel  = adr[5 +: LOG_CORES];
        debug_addr = adr[4:0];
    end

endmodule

// File: rtl/wb_bridge.sv
// Wishbone slave bridge into program memory, pad registers, core debug
// port and an entropy seed register. Debug reads wait DEBUG_LAT cycles
// for debug_rdata before acknowledging.
// Optional feature: define WB_BRIDGE_STATS_EN to add a 16-bit acknowledge
// counter, readable from the entropy region with adr[0]=1.
module wb_bridge
    import wb_bridge_pkg::*;
#(
    parameter int LOG_CORES   = DEF_LOG_CORES,
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IO_PINS     = DEF_IO_PINS,
    parameter int WB_WIDTH    = DEF_WB_WIDTH,
    parameter int DEBUG_LAT   = DEF_DEBUG_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [WB_WIDTH/8-1:0]   wbs_sel_i,
    input  logic [WB_WIDTH-1:0]     wbs_adr_i,
    input  logic [WB_WIDTH-1:0]     wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [WB_WIDTH-1:0]     wbs_dat_o,
    output logic                    prog_we,
    output logic [LOG_CORES-1:0]    prog_sel,
    output logic [PC_WIDTH-1:0]     prog_waddr,
    output logic [INSTR_WIDTH-1:0]  prog_wdata,
    output logic                    pads_we,
    output logic                    pads_waddr,
    output logic [IO_PINS-1:0]      pads_wdata,
    output logic [LOG_CORES-1:0]    debug_sel,
    output logic [4:0]              debug_addr,
    output logic                    debug_we,
    output logic [DATA_WIDTH-1:0]   debug_wdata,
    input  logic [DATA_WIDTH-1:0]   debug_rdata,
    output logic [WB_WIDTH-1:0]     entropy_word
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    region_e              dec_region;
    logic [LOG_CORES-1:0] dec_prog_sel;
    logic [PC_WIDTH-1:0]  dec_prog_waddr;
    logic                 dec_pads_waddr;
    logic [LOG_CORES-1:0] dec_debug_sel;
    logic [4:0]           dec_debug_addr;

    wb_bridge_decode #(
        .LOG_CORES (LOG_CORES),
        .PC_WIDTH  (PC_WIDTH),
        .WB_WIDTH  (WB_WIDTH)
    ) u_decode (
        .adr        (wbs_adr_i),
        .region     (dec_region),
        .prog_sel   (dec_prog_sel),
        .prog_waddr (dec_prog_waddr),
        .pads_waddr (dec_pads_waddr),
        .debug_sel  (dec_debug_sel),
        .debug_addr (dec_debug_addr)
    );

    // Expand byte-lane selects into a bit mask for entropy writes
    logic [WB_WIDTH-1:0] lane_mask;
    generate
        for (genvar gi = 0; gi < WB_WIDTH/8; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    logic req;
    assign req = wbs_cyc_i & wbs_stb_i;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e                   state_q,       state_d;
    logic [LAT_CNT_WIDTH-1:0] cnt_q,         cnt_d;
    logic                     ack_q,         ack_d;
    logic [WB_WIDTH-1:0]      dat_q,         dat_d;
    logic                     prog_we_q,     prog_we_d;
    logic [LOG_CORES-1:0]     prog_sel_q,    prog_sel_d;
    logic [PC_WIDTH-1:0]      prog_waddr_q,  prog_waddr_d;
    logic [INSTR_WIDTH-1:0]   prog_wdata_q,  prog_wdata_d;
    logic                     pads_we_q,     pads_we_d;
    logic                     pads_waddr_q,  pads_waddr_d;
    logic [IO_PINS-1:0]       pads_wdata_q,  pads_wdata_d;
    logic [LOG_CORES-1:0]     debug_sel_q,   debug_sel_d;
    logic [4:0]               debug_addr_q,  debug_addr_d;
    logic                     debug_we_q,    debug_we_d;
    logic [DATA_WIDTH-1:0]    debug_wdata_q, debug_wdata_d;
    logic [WB_WIDTH-1:0]      entropy_q,     entropy_d;

    // Value returned by an entropy-region read
    logic [WB_WIDTH-1:0]      entropy_rd;

`ifdef WB_BRIDGE_STATS_EN
    logic [STATS_WIDTH-1:0]   stats_q,       stats_d;
    assign entropy_rd = dec_pads_waddr ? WB_WIDTH'(stats_q) : entropy_q;
`else
    assign entropy_rd = entropy_q;
`endif

    // Next-state and next-output logic for the IDLE/WAIT/ACK transaction FSM
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ack_d         = 1'b0;
        dat_d         = dat_q;
        prog_we_d     = 1'b0;
        prog_sel_d    = prog_sel_q;
        prog_waddr_d  = prog_waddr_q;
        prog_wdata_d  = prog_wdata_q;
        pads_we_d     = 1'b0;
        pads_waddr_d  = pads_waddr_q;
        pads_wdata_d  = pads_wdata_q;
        debug_sel_d   = debug_sel_q;
        debug_addr_d  = debug_addr_q;
        debug_we_d    = 1'b0;
        debug_wdata_d = debug_wdata_q;
        entropy_d     = entropy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Target fields are latched for every accepted request
                    // so debug reads present a stable address while waiting
                    prog_sel_d   = dec_prog_sel;
                    prog_waddr_d = dec_prog_waddr;
                    pads_waddr_d = dec_pads_waddr;
                    debug_sel_d  = dec_debug_sel;
                    debug_addr_d = dec_debug_addr;

                    if (wbs_we_i) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        case (dec_region)
                            REGION_PROG: begin
                                prog_we_d    = 1'b1;
                                prog_wdata_d = wbs_dat_i[INSTR_WIDTH-1:0];
                            end
                            REGION_PADS: begin
                                pads_we_d    = 1'b1;
                                pads_wdata_d = wbs_dat_i[IO_PINS-1:0];
                            end
                            REGION_DEBUG: begin
                                debug_we_d    = 1'b1;
                                debug_wdata_d = wbs_dat_i[DATA_WIDTH-1:0];
                            end
                            REGION_ENTROPY: begin
                                entropy_d = (entropy_q & ~lane_mask) |
                                            (wbs_dat_i & lane_mask);
                            end
                        endcase
                    end else if (dec_region == REGION_DEBUG) begin
                        state_d = ST_WAIT;
                        cnt_d   = lat_load(DEBUG_LAT);
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        dat_d   = (dec_region == REGION_ENTROPY) ? entropy_rd : '0;
                    end
                end
            end

            ST_WAIT: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: drop it silently
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dat_d   = WB_WIDTH'(debug_rdata);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef WB_BRIDGE_STATS_EN
    // Count every acknowledge; the counter wraps naturally
    always_comb begin
        stats_d = stats_q;
        if (ack_d) begin
            stats_d = stats_q + 1'b1;
        end
    end
`endif

    // Register FSM state and all outputs; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ack_q         <= 1'b0;
            dat_q         <= '0;
            prog_we_q     <= 1'b0;
            prog_sel_q    <= '0;
            prog_waddr_q  <= '0;
            prog_wdata_q  <= '0;
            pads_we_q     <= 1'b0;
            pads_waddr_q  <= 1'b0;
            pads_wdata_q  <= '0;
            debug_sel_q   <= '0;
            debug_addr_q  <= '0;
            debug_we_q    <= 1'b0;
            debug_wdata_q <= '0;
            entropy_q     <= '0;
`ifdef WB_BRIDGE_STATS_EN
            stats_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            prog_we_q     <= prog_we_d;
            prog_sel_q    <= prog_sel_d;
            prog_waddr_q  <= prog_waddr_d;
            prog_wdata_q  <= prog_wdata_d;
            pads_we_q     <= pads_we_d;
            pads_waddr_q  <= pads_waddr_d;
            pads_wdata_q  <= pads_wdata_d;
            debug_sel_q   <= debug_sel_d;
            debug_addr_q  <= debug_addr_d;
            debug_we_q    <= debug_we_d;
            debug_wdata_q <= debug_wdata_d;
            entropy_q     <= entropy_d;
`ifdef WB_BRIDGE_STATS_EN
            stats_q       <= stats_d;
`endif
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign prog_we      = prog_we_q;
    assign prog_sel     = prog_sel_q;
    assign prog_waddr   = prog_waddr_q;
    assign prog_wdata   = prog_wdata_q;
    assign pads_we      = pads_we_q;
    assign pads_waddr   = pads_waddr_q;
    assign pads_wdata   = pads_wdata_q;
    assign debug_sel    = debug_sel_q;
    assign debug_addr   = debug_addr_q;
    assign debug_we     = debug_we_q;
    assign debug_wdata  = debug_wdata_q;
    assign entropy_word = entropy_q;

endmodule

// File: tb/tb_wb_bridge.sv
// Scoreboard testbench for wb_bridge: directed cases plus random traffic.
// Expected responses are queued by the driver and checked by a monitor
// whenever the bridge acknowledges.
module tb_wb_bridge;

    localparam int LAT = 2;
`ifdef WB_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        prog_we;
    logic [2:0]  prog_sel;
    logic [7:0]  prog_waddr;
    logic [31:0] prog_wdata;
    logic        pads_we, pads_waddr;
    logic [15:0] pads_wdata;
    logic [2:0]  debug_sel;
    logic [4:0]  debug_addr;
    logic        debug_we;
    logic [15:0] debug_wdata;
    logic [15:0] debug_rdata = '0;
    logic [31:0] entropy_word;

    always #5 clk = ~clk;

    wb_bridge #(
        .LOG_CORES(3), .PC_WIDTH(8), .INSTR_WIDTH(32), .DATA_WIDTH(16),
        .IO_PINS(16), .WB_WIDTH(32), .DEBUG_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .prog_we(prog_we), .prog_sel(prog_sel), .prog_waddr(prog_waddr),
        .prog_wdata(prog_wdata),
        .pads_we(pads_we), .pads_waddr(pads_waddr), .pads_wdata(pads_wdata),
        .debug_sel(debug_sel), .debug_addr(debug_addr), .debug_we(debug_we),
        .debug_wdata(debug_wdata), .debug_rdata(debug_rdata),
        .entropy_word(entropy_word)
    );

    typedef struct {
        bit          is_rd;
        bit          dbg_rd;
        logic [31:0] dat;
        bit          pw, padw, dw;
        logic [2:0]  psel;
        logic [7:0]  pwa;
        logic [31:0] pwd;
        bit          pa;
        logic [15:0] pd;
        logic [2:0]  dsel;
        logic [4:0]  da;
        logic [15:0] dwd;
        logic [31:0] ent;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    // Reference model state
    logic [31:0] m_ent = '0;
    logic [31:0] m_last = '0;
    int          m_stats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every acknowledge against the head of the scoreboard
    bit   mon_en = 1'b0;
    bit   prev_ack = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_ack) chk("ack_single_cycle", {31'd0, wbs_ack_o}, 32'd0);
            if (wbs_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dat_o", wbs_dat_o, mon_e.dat);
                    chk("prog_we", {31'd0, prog_we}, {31'd0, mon_e.pw});
                    chk("pads_we", {31'd0, pads_we}, {31'd0, mon_e.padw});
                    chk("debug_we", {31'd0, debug_we}, {31'd0, mon_e.dw});
                    chk("entropy_word", entropy_word, mon_e.ent);
                    if (mon_e.pw) begin
                        chk("prog_sel", {29'd0, prog_sel}, {29'd0, mon_e.psel});
                        chk("prog_waddr", {24'd0, prog_waddr}, {24'd0, mon_e.pwa});
                        chk("prog_wdata", prog_wdata, mon_e.pwd);
                    end
                    if (mon_e.padw) begin
                        chk("pads_waddr", {31'd0, pads_waddr}, {31'd0, mon_e.pa});
                        chk("pads_wdata", {16'd0, pads_wdata}, {16'd0, mon_e.pd});
                    end
                    if (mon_e.dw || mon_e.dbg_rd) begin
                        chk("debug_sel", {29'd0, debug_sel}, {29'd0, mon_e.dsel});
                        chk("debug_addr", {27'd0, debug_addr}, {27'd0, mon_e.da});
                    end
                    if (mon_e.dw) chk("debug_wdata", {16'd0, debug_wdata}, {16'd0, mon_e.dwd});
                    $display("txn %s dat_o=0x%08h ent=0x%08h we={%0b%0b%0b}",
                             mon_e.is_rd ? "RD" : "WR", wbs_dat_o, entropy_word,
                             prog_we, pads_we, debug_we);
                end
            end else begin
                chk("strobe_without_ack", {29'd0, prog_we, pads_we, debug_we}, 32'd0);
            end
        end
        prev_ack <= wbs_ack_o;
    end

    // Build the expected response from the address map rules and queue it
    task automatic predict(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [15:0] rdata);
        exp_t e;
        e = '{default: '0};
        e.is_rd = !we;
        case (adr[31:30])
            2'b00: if (we) begin
                e.pw = 1'b1; e.psel = adr[10:8]; e.pwa = adr[7:0]; e.pwd = dat;
            end else m_last = 32'd0;
            2'b01: if (we) begin
                e.padw = 1'b1; e.pa = adr[0]; e.pd = dat[15:0];
            end else m_last = 32'd0;
            2'b10: begin
                e.dsel = adr[7:5]; e.da = adr[4:0];
                if (we) begin
                    e.dw = 1'b1; e.dwd = dat[15:0];
                end else begin
                    e.dbg_rd = 1'b1; m_last = {16'd0, rdata};
                end
            end
            default: if (we) begin
                for (int k = 0; k < 4; k++)
                    if (sel[k]) m_ent[8*k +: 8] = dat[8*k +: 8];
            end else begin
                m_last = (STATS && adr[0]) ? 32'(m_stats) : m_ent;
            end
        endcase
        e.dat = m_last;
        e.ent = m_ent;
        m_stats = (m_stats + 1) % 65536;
        exp_q.push_back(e);
    endtask

    // Issue one Wishbone transaction and check its acknowledge latency
    task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [15:0] rdata);
        int  n;
        int  lat_req;
        bit  got;
        lat_req = (adr[31:30] == 2'b10 && !we) ? LAT + 1 : 1;
        predict(we, adr, dat, sel, rdata);
        debug_rdata = rdata;
        wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (wbs_ack_o) got = 1'b1;
        end
        if (got) chk("ack_latency", 32'(n), 32'(lat_req));
        else begin
            chk("ack_timeout", 32'd0, 32'd1);
            if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // Start a debug read and drop cyc while it waits: no ack must follow
    task automatic do_abort(input logic [31:0] adr);
        debug_rdata = 16'h5A5A;
        wbs_we_i = 1'b0; wbs_adr_i = adr; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            chk("abort_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        end
    endtask

    // Pads write, then assert reset in the middle of its ACK cycle
    task automatic do_reset_in_ack();
        int n;
        wbs_we_i = 1'b1; wbs_adr_i = 32'h4000_0001; wbs_dat_i = 32'h0000_BEEF;
        wbs_sel_i = 4'hF; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        n = 0;
        while (!wbs_ack_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_ack_seen", {31'd0, wbs_ack_o}, 32'd1);
        chk("rst_pads_we_seen", {31'd0, pads_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack_cleared", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_pads_we_cleared", {31'd0, pads_we}, 32'd0);
        chk("rst_pads_wdata_cleared", {16'd0, pads_wdata}, 32'd0);
        chk("rst_entropy_cleared", entropy_word, 32'd0);
        chk("rst_dat_cleared", wbs_dat_o, 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        m_ent = '0; m_last = '0; m_stats = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] adr;
        // Reset state
        #3;
        chk("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("reset_dat", wbs_dat_o, 32'd0);
        chk("reset_we", {29'd0, prog_we, pads_we, debug_we}, 32'd0);
        chk("reset_entropy", entropy_word, 32'd0);
        chk("reset_fields", {prog_sel, prog_waddr, debug_sel, debug_addr, pads_waddr}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_txn(1'b1, 32'h0000_05DB, 32'hFFFF_FFFF, 4'hF, 16'h0);
        do_txn(1'b0, 32'h8000_004A, 32'h0, 4'h0, 16'hF0AA);
        do_txn(1'b1, 32'hC000_0000, 32'h1234_5678, 4'h3, 16'h0);
        chk("entropy_lane_write", entropy_word, 32'h0000_5678);
        do_txn(1'b0, 32'hC000_0000, 32'h0, 4'h0, 16'h0);
        do_txn(1'b0, 32'h0000_0123, 32'h0, 4'h0, 16'h0);
        do_abort(32'h8000_0021);
        do_txn(1'b1, 32'h4000_0000, 32'h0000_A5A5, 4'hF, 16'h0);
        do_reset_in_ack();

        // Three acks after reset, then read the statistics address
        do_txn(1'b1, 32'h8000_0003, 32'h0000_1111, 4'hF, 16'h0);
        do_txn(1'b0, 32'h4000_0001, 32'h0, 4'h0, 16'h0);
        do_txn(1'b1, 32'hC000_0000, 32'hCAFE_0000, 4'hC, 16'h0);
        do_txn(1'b0, 32'hC000_0001, 32'h0, 4'h0, 16'h0);

        // Random traffic across all regions
        for (int i = 0; i < 80; i++) begin
            r = 2'($urandom_range(0, 3));
            adr = {r, 30'($urandom)};
            do_txn(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
